// File: rtl/spi_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_arbiter : session-level arbiter sharing one spi_core between two masters
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_arbiter #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  output logic       gnt0,
  input  logic [7:0] data_tx0,
  input  logic       txn_start0,
  output logic       txn_done0,
  input  logic       force_clock0,
  input  logic [1:0] ce0_n,
  input  logic       req1,
  output logic       gnt1,
  input  logic [7:0] data_tx1,
  input  logic       txn_start1,
  output logic       txn_done1,
  input  logic       force_clock1,
  input  logic       ce1_n,
  output logic [7:0] core_data_tx,
  output logic       core_txn_start,
  input  logic       core_txn_done,
  output logic       core_force_clock,
  output logic       spi_flash_ce_n,
  output logic       spi_ram_ce_n,
  output logic       spi_aux_ce_n
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_OWN0  = 3'd1;
  localparam logic [2:0] c_OWN1  = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_GAP   = 3'd4;

  localparam logic [3:0] c_GAP_LAST = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  // With no gap required, sessions hand straight back to IDLE.
  localparam logic [2:0] c_AFTER    = (GAP_CYCLES == 0) ? c_IDLE : c_GAP;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_last_owner;
  logic       r_in_flight;
  logic [3:0] r_gap_cnt;

  logic       w_own0;
  logic       w_own1;
  logic       w_fwd_start;
  logic       w_busy;

  // DRAIN keeps the previous owner, which is always r_last_owner.
  assign w_own0 = (r_state == c_OWN0) || ((r_state == c_DRAIN) && !r_last_owner);
  assign w_own1 = (r_state == c_OWN1) || ((r_state == c_DRAIN) &&  r_last_owner);

  assign w_fwd_start = !r_in_flight &&
                       (((r_state == c_OWN0) && txn_start0) ||
                        ((r_state == c_OWN1) && txn_start1));
  assign w_busy = w_fwd_start || (r_in_flight && !core_txn_done);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_last_owner <= 1'b1;
      r_in_flight  <= 1'b0;
      r_gap_cnt    <= 4'd0;
    end else begin
      r_state <= w_next;
      r_gnt0  <= (w_next == c_OWN0) || ((w_next == c_DRAIN) && !r_last_owner);
      r_gnt1  <= (w_next == c_OWN1) || ((w_next == c_DRAIN) &&  r_last_owner);
      if (w_next == c_OWN0) begin
        r_last_owner <= 1'b0;
      end else if (w_next == c_OWN1) begin
        r_last_owner <= 1'b1;
      end
      if (w_fwd_start) begin
        r_in_flight <= 1'b1;
      end else if (core_txn_done) begin
        r_in_flight <= 1'b0;
      end
      r_gap_cnt <= (r_state == c_GAP) ? (r_gap_cnt + 4'd1) : 4'd0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (req0 && (!req1 || r_last_owner)) begin
          w_next = c_OWN0;
        end else if (req1) begin
          w_next = c_OWN1;
        end
      end
      c_OWN0:  if (!req0) w_next = w_busy ? c_DRAIN : c_AFTER;
      c_OWN1:  if (!req1) w_next = w_busy ? c_DRAIN : c_AFTER;
      c_DRAIN: if (core_txn_done) w_next = c_AFTER;
      c_GAP:   if (r_gap_cnt == c_GAP_LAST) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    core_data_tx     = 8'h00;
    core_txn_start   = w_fwd_start;
    core_force_clock = 1'b0;
    spi_flash_ce_n   = 1'b1;
    spi_ram_ce_n     = 1'b1;
    spi_aux_ce_n     = 1'b1;
    txn_done0        = 1'b0;
    txn_done1        = 1'b0;
    if (w_own0) begin
      core_data_tx     = data_tx0;
      core_force_clock = force_clock0;
      spi_flash_ce_n   = ce0_n[0];
      spi_ram_ce_n     = ce0_n[1];
      txn_done0        = core_txn_done;
    end else if (w_own1) begin
      core_data_tx     = data_tx1;
      core_force_clock = force_clock1;
      spi_aux_ce_n     = ce1_n;
      txn_done1        = core_txn_done;
    end
  end

  assign gnt0 = r_gnt0;
  assign gnt1 = r_gnt1;

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_arbiter : directed self-checking bench for spi_arbiter (GAP_CYCLES=2)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_spi_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic       gnt0, gnt1;
  logic [7:0] data_tx0, data_tx1;
  logic       txn_start0, txn_start1;
  logic       txn_done0, txn_done1;
  logic       force_clock0, force_clock1;
  logic [1:0] ce0_n;
  logic       ce1_n;
  logic [7:0] core_data_tx;
  logic       core_txn_start;
  logic       core_txn_done;
  logic       core_force_clock;
  logic       spi_flash_ce_n, spi_ram_ce_n, spi_aux_ce_n;

  int checks   = 0;
  int failures = 0;
  int cur;

  spi_arbiter #(.GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .gnt0(gnt0), .data_tx0(data_tx0), .txn_start0(txn_start0),
    .txn_done0(txn_done0), .force_clock0(force_clock0), .ce0_n(ce0_n),
    .req1(req1), .gnt1(gnt1), .data_tx1(data_tx1), .txn_start1(txn_start1),
    .txn_done1(txn_done1), .force_clock1(force_clock1), .ce1_n(ce1_n),
    .core_data_tx(core_data_tx), .core_txn_start(core_txn_start),
    .core_txn_done(core_txn_done), .core_force_clock(core_force_clock),
    .spi_flash_ce_n(spi_flash_ce_n), .spi_ram_ce_n(spi_ram_ce_n),
    .spi_aux_ce_n(spi_aux_ce_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"},  {6'd0, gnt1, gnt0}, 8'h00);
    chk({tag, "_cs"},   {5'd0, spi_aux_ce_n, spi_ram_ce_n, spi_flash_ce_n}, 8'h07);
    chk({tag, "_core"}, {6'd0, core_txn_start, core_force_clock}, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req0 = 0; req1 = 0;
    data_tx0 = 8'h00; data_tx1 = 8'h00;
    txn_start0 = 0; txn_start1 = 0; force_clock0 = 0; force_clock1 = 0;
    ce0_n = 2'b11; ce1_n = 1'b1; core_txn_done = 0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk_idle_outputs("reset");
    chk("reset_data", core_data_tx, 8'h00);
    chk("reset_done", {6'd0, txn_done1, txn_done0}, 8'h00);

    // 1: single requester, one byte
    req0 = 1;
    tick();
    chk("t1_gnt", {6'd0, gnt1, gnt0}, 8'h01);
    ce0_n = 2'b10; data_tx0 = 8'h03; txn_start0 = 1;
    #1;
    chk("t1_start", {7'd0, core_txn_start}, 8'h01);
    chk("t1_data", core_data_tx, 8'h03);
    chk("t1_cs", {5'd0, spi_aux_ce_n, spi_ram_ce_n, spi_flash_ce_n}, 8'h06);
    tick();
    txn_start0 = 0; core_txn_done = 1;
    #1;
    chk("t1_done", {6'd0, txn_done1, txn_done0}, 8'h01);
    tick();
    core_txn_done = 0; req0 = 0; ce0_n = 2'b11;
    tick();
    chk("t1_gap_gnt", {6'd0, gnt1, gnt0}, 8'h00);
    tick(); tick();

    // 2: simultaneous requests after reset, then handoff timing
    do_reset();
    req0 = 1; req1 = 1;
    tick();
    chk("t2_first", {6'd0, gnt1, gnt0}, 8'h01);
    req0 = 0; ce1_n = 1'b0;
    tick();
    chk_idle_outputs("t2_gap1");
    tick();
    chk_idle_outputs("t2_gap2");
    tick();
    chk("t2_idle_gnt", {6'd0, gnt1, gnt0}, 8'h00);
    tick();
    chk("t2_gnt1", {6'd0, gnt1, gnt0}, 8'h02);
    chk("t2_aux", {7'd0, spi_aux_ce_n}, 8'h00);
    ce1_n = 1'b1;

    // 3: round-robin with short sessions
    req0 = 1;
    cur = 1;
    for (int k = 0; k < 4; k++) begin
      if (cur == 1) req1 = 0; else req0 = 0;
      tick();
      if (cur == 1) req1 = 1; else req0 = 1;
      tick(); tick(); tick();
      cur = 1 - cur;
      chk($sformatf("t3_rr%0d", k), {6'd0, gnt1, gnt0}, (cur == 0) ? 8'h01 : 8'h02);
    end

    // 4: drop request with a byte in flight
    do_reset();
    req0 = 1; req1 = 0;
    tick();
    ce0_n = 2'b10; txn_start0 = 1;
    tick();
    txn_start0 = 0; req0 = 0;
    tick();
    chk("t4_drain_gnt", {6'd0, gnt1, gnt0}, 8'h01);
    chk("t4_drain_cs", {7'd0, spi_flash_ce_n}, 8'h00);
    txn_start0 = 1;
    #1;
    chk("t4_no_start", {7'd0, core_txn_start}, 8'h00);
    txn_start0 = 0;
    tick();
    chk("t4_hold_gnt", {6'd0, gnt1, gnt0}, 8'h01);
    core_txn_done = 1;
    #1;
    chk("t4_done", {6'd0, txn_done1, txn_done0}, 8'h01);
    tick();
    core_txn_done = 0;
    chk("t4_gap_gnt", {6'd0, gnt1, gnt0}, 8'h00);
    chk("t4_gap_cs", {7'd0, spi_flash_ce_n}, 8'h01);
    ce0_n = 2'b11;
    tick(); tick();

    // 5: non-owner isolation during OWN0
    req0 = 1;
    tick();
    chk("t5_gnt", {6'd0, gnt1, gnt0}, 8'h01);
    data_tx0 = 8'h5C; data_tx1 = 8'hAA;
    txn_start1 = 1; force_clock1 = 1; ce1_n = 1'b0;
    #1;
    chk("t5_iso_start", {7'd0, core_txn_start}, 8'h00);
    chk("t5_iso_force", {7'd0, core_force_clock}, 8'h00);
    chk("t5_iso_aux", {7'd0, spi_aux_ce_n}, 8'h01);
    chk("t5_iso_data", core_data_tx, 8'h5C);
    core_txn_done = 1;
    #1;
    chk("t5_iso_done1", {7'd0, txn_done1}, 8'h00);
    core_txn_done = 0; txn_start1 = 0; force_clock1 = 0; ce1_n = 1'b1;
    force_clock0 = 1; txn_start0 = 1; ce0_n = 2'b01;
    #1;
    chk("t5_own_force", {7'd0, core_force_clock}, 8'h01);
    chk("t5_own_ram", {6'd0, spi_ram_ce_n, spi_flash_ce_n}, 8'h01);
    tick();
    force_clock0 = 0;
    #1;
    chk("t5_proto_drop", {7'd0, core_txn_start}, 8'h00);
    txn_start0 = 0;

    // 6: reset mid-session with a byte in flight
    rst_n = 0; req1 = 1;
    tick();
    #1;
    chk_idle_outputs("t6_rst");
    rst_n = 1;
    tick();
    chk("t6_tie", {6'd0, gnt1, gnt0}, 8'h01);
    txn_start0 = 1;
    #1;
    chk("t6_inflight_clr", {7'd0, core_txn_start}, 8'h01);
    txn_start0 = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares the single spi_core byte engine between two requesters:
  - Requester 0: mem_ctrl (flash/RAM chip selects).
  - Requester 1: a register-mapped SPI peripheral with its own chip select.
- Grants are per session. A requester holds req for a whole multi-byte command, and the arbiter keeps the grant until req drops and no byte is in flight.
- Sits between the requesters and spi_core in soc. It also owns the external chip-select outputs so that no two devices are ever selected at once.

Parameters:
- GAP_CYCLES, 2: minimum cycles with all chip selects high between sessions; 0 is legal; max 15.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- req0  input  1  requester 0 session request, level
- gnt0  output  1  requester 0 owns the core
- data_tx0  input  8  requester 0 byte to send
- txn_start0  input  1  requester 0 byte start pulse
- txn_done0  output  1  byte-complete pulse to requester 0
- force_clock0  input  1  requester 0 force_clock
- ce0_n  input  2  requester 0 chip selects {ram, flash}, active-low
- req1  input  1  requester 1 session request, level
- gnt1  output  1  requester 1 owns the core
- data_tx1  input  8  requester 1 byte to send
- txn_start1  input  1  requester 1 byte start pulse
- txn_done1  output  1  byte-complete pulse to requester 1
- force_clock1  input  1  requester 1 force_clock
- ce1_n  input  1  requester 1 chip select, active-low
- core_data_tx  output  8  to spi_core data_tx
- core_txn_start  output  1  to spi_core txn_start
- core_txn_done  input  1  from spi_core txn_done
- core_force_clock  output  1  to spi_core force_clock
- spi_flash_ce_n  output  1  external flash CS
- spi_ram_ce_n  output  1  external RAM CS
- spi_aux_ce_n  output  1  external peripheral CS
- (core data_rx is wired straight to both requesters and is not routed through this block.)

Behaviour:
- States: IDLE, OWN0, OWN1, DRAIN, GAP.
  - gnt0/gnt1 are registered: gnt0=1 only in OWN0; gnt1=1 only in OWN1.
  - In DRAIN the grant of the current owner stays asserted.
- Reset:
  - State becomes IDLE.
  - gnt0=gnt1=0, txn_done0=txn_done1=0.
  - core_txn_start=0, core_force_clock=0, core_data_tx=0.
  - All three CS outputs=1.
  - in_flight=0, last_owner=1, so requester 0 wins the first tie.
  - Reset mid-session drops everything immediately; no drain.
- IDLE:
  - If only one req is high, go to OWNi.
  - If both are high, grant the requester != last_owner (round-robin).
  - Grant is visible the cycle after req is sampled (1-cycle latency).
  - Set last_owner on entry to OWNi.
- OWNi forwarding, combinational from the owner:
  - core_data_tx = data_txi.
  - core_txn_start = txn_starti & !in_flight.
  - core_force_clock = force_clocki.
  - Owner's CS passes through; all other CS outputs are forced to 1.
- Non-owner isolation:
  - A non-owner's txn_start, force_clock and ce_n are ignored entirely.
  - Its txn_done stays 0.
- in_flight:
  - Set on a forwarded core_txn_start; cleared on core_txn_done.
  - A txn_start from the owner while in_flight is dropped; this is a requester protocol error, with no retry.
- Done routing: core_txn_done is routed combinationally to txn_donei of the owner only, including in DRAIN. A txn_done arriving in IDLE or GAP is discarded.
- Leaving OWNi when reqi=0:
  - in_flight=0: go to GAP.
  - in_flight=1: go to DRAIN. Hold the grant and the owner's CS, and forward no new starts.
  - DRAIN exits to GAP on the cycle core_txn_done arrives.
- GAP:
  - gnt=0, all CS=1, core_force_clock=0, core_txn_start=0.
  - Counter runs GAP_CYCLES cycles, then IDLE.
  - GAP_CYCLES=0: skip GAP and go straight to IDLE.
  - Requests arriving during GAP are held pending and arbitrated in IDLE.
- Timing: minimum time from one owner's req drop to the other owner's gnt is GAP_CYCLES+2 cycles.
- No preemption: an owner holding req indefinitely starves the other. Requesters must bound their sessions.
- Simultaneous event, req drop and core_txn_done in the same OWN cycle: treat the byte as complete and go to GAP.

Test Plan:
1. Reset, then req0=1 alone → gnt0=1 after 1 cycle. Owner drives ce0_n=2'b10, data_tx0=8'h03, start pulse → core_txn_start=1, core_data_tx=8'h03, spi_flash_ce_n=0, spi_aux_ce_n=1. core_txn_done → txn_done0 pulse, txn_done1=0.
2. req0 and req1 rise in the same cycle after reset → gnt0 first. Drop req0 with req1 still high → gnt1 rises exactly GAP_CYCLES+2=4 cycles later; all CS=1 during GAP.
3. Both requesting continuously with short sessions → grants alternate 0,1,0,1; neither is granted twice in a row.
4. req0 dropped while a byte is in flight → gnt0 and spi_flash_ce_n stay asserted until core_txn_done. txn_done0 pulses, then GAP.
5. During OWN0, requester 1 pulses txn_start1, asserts force_clock1 and ce1_n=0 → core_txn_start, core_force_clock and spi_aux_ce_n are unaffected.
6. rst_n=0 mid-session with in_flight=1 → next cycle all gnt=0, all CS=1, state IDLE. Post-reset tie → requester 0 wins.
